alu_arbiter_seq: RTL

//  Shares one combinational 4-bit ALU (ports A,B,c_in,Op -> R,zero,carry,sign) between two requesters.

---
 rtl/alu_arbiter_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter_seq.sv
// Two-requester round-robin front end for a shared combinational 4-bit ALU.
// One operation is in flight at a time: IDLE grants, EXEC drives the ALU for
// one cycle and captures its outputs, RESP holds the tagged result until taken.
`timescale 1ns/1ps
module alu_arbiter_seq #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_sign,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             id_q, id_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_r_q, rsp_r_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_sign_q, rsp_sign_d;
    logic [CNTW-1:0]  op_count_q, op_count_d;
    logic             grant;
    logic             accept;

    // Round-robin pick: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end
        req0_ready = (state_q == IDLE) && !grant && req0_valid;
        req1_ready = (state_q == IDLE) &&  grant && req1_valid;
        accept     = req0_ready || req1_ready;
    end

    // Next-state and register updates for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_r_d      = rsp_r_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_sign_d   = rsp_sign_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d          = grant ? req1_a   : req0_a;
                    b_d          = grant ? req1_b   : req0_b;
                    cin_d        = grant ? req1_cin : req0_cin;
                    op_d         = grant ? req1_op  : req0_op;
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_id_d    = id_q;
                rsp_r_d     = alu_r;
                rsp_zero_d  = alu_zero;
                rsp_sign_d  = alu_sign;
                // Logical opcodes (MSB set) never report a carry, whatever the ALU drives.
                rsp_carry_d = alu_carry & ~op_q[OPW-1];
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears every visible output, last_grant starts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_r_q      <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_sign_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_r_q      <= rsp_r_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_sign_q   <= rsp_sign_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_cin   = cin_q;
    assign alu_op    = op_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_sign  = rsp_sign_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule
